// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the NOP encoding and the fetch FSM state type.
package cpu_pkg;

  localparam int PC_W = 8;
  localparam int INSTR_W = 32;
  localparam int CNT_W = 16;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. It loads a fetched word, a squashed NOP or a bubble while the pipe is enabled,
// and it holds its contents while the pipe is stalled.
module ifid_reg #(
  parameter int                 PC_W     = cpu_pkg::PC_W,
  parameter int                 INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_le,
  input  logic               i_adv,
  input  logic               i_squash,
  input  logic [INSTR_W-1:0] i_word,
  input  logic [PC_W-1:0]    i_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc,
  output logic               o_valid
);

  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc;
  logic               r_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_instr <= NOP_WORD;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_le) begin
      if (i_adv) begin
        r_instr <= i_squash ? NOP_WORD : i_word;
        r_valid <= !i_squash;
        r_pc    <= i_pc;
      end else begin
        // The pipe is enabled but no word has arrived, so a bubble is loaded and the previous PC is kept.
        r_instr <= NOP_WORD;
        r_valid <= 1'b0;
      end
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage. It keeps PC and nPC with delayed-branch semantics, fetches over a req/ack
// handshake that can add wait states, and drives the IF/ID register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                 PC_W     = cpu_pkg::PC_W,
  parameter int                 INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [PC_W-1:0]    RESET_PC = '0,
  parameter logic [INSTR_W-1:0] NOP_WORD = cpu_pkg::NOP_WORD,
  parameter int                 CNT_W    = cpu_pkg::CNT_W
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               LE,
  input  logic               S,
  input  logic               TA_sel,
  input  logic [PC_W-1:0]    TA,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    pc_q,
  output logic [PC_W-1:0]    npc_q,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic               ifid_valid,
  output logic [CNT_W-1:0]   stall_cnt,
  output fetch_state_t       dbg_state
);

  // Handshake: imem_req is high in FETCH with the address on imem_addr. The word is taken in a cycle where
  // imem_req and imem_ack are both high. An ack that arrives while the pipe is stalled parks the word in
  // r_hold_buf and drops imem_req until LE releases the pipe.
  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_npc;
  logic [INSTR_W-1:0] r_hold_buf;
  logic [CNT_W-1:0]   r_stall;
  logic               w_adv;
  logic               w_capture;
  logic [INSTR_W-1:0] w_word;
  logic [PC_W-1:0]    w_ta_aligned;
  logic               w_unused_ta;

  assign w_ta_aligned = {TA[PC_W-1:2], 2'b00};
  assign w_unused_ta  = ^TA[1:0];

  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    w_adv       = 1'b0;
    w_capture   = 1'b0;
    w_word      = imem_rdata;
    case (r_state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (LE) begin
            w_adv = 1'b1;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        w_word = r_hold_buf;
        if (LE) begin
          w_adv       = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_hold_buf <= NOP_WORD;
    end else if (w_capture) begin
      r_hold_buf <= imem_rdata;
    end
  end

  // A taken branch redirects only nPC, so the delay-slot word at PC still issues on its advance.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_pc  <= RESET_PC;
      r_npc <= RESET_PC + PC_W'(4);
    end else begin
      if (w_adv) begin
        r_pc <= r_npc;
      end
      if (TA_sel) begin
        r_npc <= w_ta_aligned;
      end else if (w_adv) begin
        r_npc <= r_npc + PC_W'(4);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_stall <= '0;
    end else if (!w_adv && (r_stall != '1)) begin
      r_stall <= r_stall + CNT_W'(1);
    end
  end

  ifid_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .NOP_WORD(NOP_WORD)
  ) u_ifid_reg (
    .i_clk   (Clk),
    .i_rst   (Rst),
    .i_le    (LE),
    .i_adv   (w_adv),
    .i_squash(S),
    .i_word  (w_word),
    .i_pc    (r_pc),
    .o_instr (ifid_instr),
    .o_pc    (ifid_pc),
    .o_valid (ifid_valid)
  );

  assign imem_addr = r_pc;
  assign pc_q      = r_pc;
  assign npc_q     = r_npc;
  assign stall_cnt = r_stall;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage. An instruction memory model with programmable wait states feeds the DUT, and a
// queue of expected {pc, instr} pairs is popped each time IF/ID loads a valid instruction.
module tb_fetch_stage;
  import cpu_pkg::*;

  localparam int CW = 4;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         LE = 1'b1;
  logic         S = 1'b0;
  logic         TA_sel = 1'b0;
  logic [7:0]   TA = 8'h00;
  logic         imem_req;
  logic [7:0]   imem_addr;
  logic         imem_ack;
  logic [31:0]  imem_rdata;
  logic [7:0]   pc_q;
  logic [7:0]   npc_q;
  logic [31:0]  ifid_instr;
  logic [7:0]   ifid_pc;
  logic         ifid_valid;
  logic [CW-1:0] stall_cnt;
  fetch_state_t dbg_state;

  int           n_total = 0;
  int           n_bad = 0;
  logic [39:0]  exp_q[$];
  logic [39:0]  sb_e;
  int           wait_n = 0;
  logic [31:0]  salt = 32'h0;
  logic [3:0]   wcnt;
  logic         le_prev;

  fetch_stage #(.CNT_W(CW)) dut (
    .Clk(Clk), .Rst(Rst), .LE(LE), .S(S), .TA_sel(TA_sel), .TA(TA),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc_q(pc_q), .npc_q(npc_q), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_valid(ifid_valid), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] rom(logic [7:0] a);
    return {8'hC3, a, ~a, a ^ 8'h5A};
  endfunction

  // Memory model: ack after wait_n request cycles, content scrambled by salt.
  assign imem_ack   = imem_req && (int'(wcnt) >= wait_n);
  assign imem_rdata = rom(imem_addr) ^ salt;

  always @(posedge Clk) begin
    if (Rst || !imem_req || imem_ack) wcnt <= 4'd0;
    else if (wcnt != 4'hF) wcnt <= wcnt + 4'd1;
    le_prev <= LE && !Rst;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (le_prev === 1'b1 && ifid_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_qsize", 64'(exp_q.size()), 64'd1);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_ifid", {ifid_pc, ifid_instr}, sb_e);
      end
    end
  end

  task automatic push_exp(input logic [7:0] pc, input logic [31:0] sl);
    exp_q.push_back({pc, rom(pc) ^ sl});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1; LE = 1'b1; S = 1'b0; TA_sel = 1'b0; TA = 8'h00; salt = 32'h0;
    step(2);
    Rst = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    @(negedge Clk);
    #1;
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    // Zero-wait memory: one instruction per cycle.
    wait_n = 0;
    do_reset();
    chk("rst_pc", pc_q, 8'h00);
    chk("rst_npc", npc_q, 8'h04);
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_ifid_pc", ifid_pc, 8'h00);
    chk("rst_valid", ifid_valid, 1'b0);
    chk("rst_stall", stall_cnt, 4'd0);
    chk("rst_state", dbg_state, FETCH);
    chk("rst_req", imem_req, 1'b1);
    chk("rst_addr", imem_addr, 8'h00);
    for (int i = 0; i < 6; i++) push_exp(8'(4 * i), 32'h0);
    step(6);
    chk("zw_pc", pc_q, 8'd24);
    chk("zw_npc", npc_q, 8'd28);
    chk("zw_addr", imem_addr, 8'd24);
    chk("zw_ifid_pc", ifid_pc, 8'd20);
    chk("zw_stall", stall_cnt, 4'd0);
    drain_check("zw_drain");

    // Two wait states per fetch produce two bubbles per instruction.
    wait_n = 2;
    do_reset();
    for (int i = 0; i < 3; i++) push_exp(8'(4 * i), 32'h0);
    step(1);
    chk("ws_bubble_valid", ifid_valid, 1'b0);
    chk("ws_bubble_pc", pc_q, 8'h00);
    chk("ws_stall1", stall_cnt, 4'd1);
    step(2);
    chk("ws_pc1", pc_q, 8'h04);
    chk("ws_ifid_pc", ifid_pc, 8'h00);
    step(6);
    chk("ws_pc3", pc_q, 8'h0C);
    chk("ws_stall6", stall_cnt, 4'd6);
    drain_check("ws_drain");

    // An ack during a stall parks the word in HOLD; a branch in HOLD moves only nPC.
    wait_n = 0;
    do_reset();
    push_exp(8'h00, 32'h0); push_exp(8'h04, 32'h0); push_exp(8'h08, 32'h0);
    push_exp(8'h80, 32'h5A5A_0000);
    step(2);
    LE = 1'b0;
    step(1);
    chk("hold_state", dbg_state, HOLD);
    chk("hold_req", imem_req, 1'b0);
    chk("hold_pc", pc_q, 8'h08);
    TA_sel = 1'b1; TA = 8'h81;
    step(1);
    TA_sel = 1'b0;
    chk("hold_npc_redirect", npc_q, 8'h80);
    chk("hold_pc2", pc_q, 8'h08);
    step(1);
    chk("hold_stall", stall_cnt, 4'd3);
    chk("hold_ifid_pc", ifid_pc, 8'h04);
    LE = 1'b1; salt = 32'h5A5A_0000;
    step(1);
    chk("rel_pc", pc_q, 8'h80);
    chk("rel_instr", ifid_instr, {8'hC3, 8'h08, 8'hF7, 8'h52});
    chk("rel_state", dbg_state, FETCH);
    step(1);
    chk("rel_next_pc", ifid_pc, 8'h80);
    drain_check("hold_drain");

    // Delayed branch: the delay slot and the word after it issue before the target.
    do_reset();
    for (int i = 0; i < 6; i++) push_exp(8'(4 * i), 32'h0);
    push_exp(8'h40, 32'h0); push_exp(8'h44, 32'h0);
    step(4);
    chk("br_pc_pre", pc_q, 8'h10);
    TA_sel = 1'b1; TA = 8'h42;
    step(1);
    TA_sel = 1'b0;
    chk("br_slot_ifid", ifid_pc, 8'h10);
    chk("br_pc", pc_q, 8'h14);
    chk("br_npc", npc_q, 8'h40);
    step(1);
    chk("br_pc_target", pc_q, 8'h40);
    step(2);
    chk("br_pc_end", pc_q, 8'h48);
    drain_check("br_drain");

    // Squash on a loading edge, PC wrap at 8'hFC, and S ignored while LE=0.
    do_reset();
    push_exp(8'h00, 32'h0); push_exp(8'h04, 32'h0); push_exp(8'hF8, 32'h0);
    push_exp(8'h00, 32'h0); push_exp(8'h04, 32'h0);
    TA_sel = 1'b1; TA = 8'hF8;
    step(1);
    TA_sel = 1'b0;
    step(2);
    chk("wrap_pc", pc_q, 8'hFC);
    chk("wrap_npc", npc_q, 8'h00);
    S = 1'b1;
    step(1);
    S = 1'b0;
    chk("sq_valid", ifid_valid, 1'b0);
    chk("sq_instr", ifid_instr, 32'h0);
    chk("sq_ifid_pc", ifid_pc, 8'hFC);
    chk("sq_pc", pc_q, 8'h00);
    chk("sq_npc", npc_q, 8'h04);
    step(1);
    chk("sq_after_valid", ifid_valid, 1'b1);
    LE = 1'b0; S = 1'b1;
    step(1);
    chk("stall_s_valid", ifid_valid, 1'b1);
    chk("stall_s_ifid_pc", ifid_pc, 8'h00);
    LE = 1'b1; S = 1'b0;
    step(1);
    chk("stall_s_release", ifid_pc, 8'h04);
    drain_check("sq_drain");

    // A reset that lands on the same edge as an ack discards the ack.
    wait_n = 3;
    do_reset();
    step(3);
    Rst = 1'b1;
    step(1);
    Rst = 1'b0;
    chk("rw_pc", pc_q, 8'h00);
    chk("rw_npc", npc_q, 8'h04);
    chk("rw_valid", ifid_valid, 1'b0);
    chk("rw_stall", stall_cnt, 4'd0);
    push_exp(8'h00, 32'h0);
    step(4);
    chk("rw_pc_after", pc_q, 8'h04);
    drain_check("rw_drain");

    // The stall counter saturates at all-ones.
    wait_n = 0;
    do_reset();
    push_exp(8'h00, 32'h0);
    LE = 1'b0;
    step(20);
    chk("sat_stall", stall_cnt, 4'hF);
    chk("sat_state", dbg_state, HOLD);
    LE = 1'b1;
    step(1);
    chk("sat_hold_stall", stall_cnt, 4'hF);
    drain_check("sat_drain");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
